aclk_time_counter_gen: RTL and testbench

Parametrised BCD time-of-day counter for the alarm clock datapath. Counts HH:MM:SS in 24 h form, with optional seconds digits. Supports a validated parallel load, count enable and rollover strobes. Also provides a registered 12 h display view with an AM/PM flag for the display and alarm-compare logic.

---
 rtl/aclk_pkg.sv | 40 ++++
 rtl/aclk_bcd_mod60.sv | 60 ++++++
 rtl/aclk_time_counter_gen.sv | 197 +++++++++++++++++++
 tb/tb_aclk_time_counter_gen.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/aclk_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : aclk_pkg                                                   |
// | Description : Shared types, digit limits and the legal-time check for    |
// |               the alarm clock time-of-day counter.                       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package aclk_pkg;

  typedef logic [3:0] bcd_t;

  localparam bcd_t       c_ms60_max     = 4'd5;   // tens digit of sec/min
  localparam bcd_t       c_ls_max       = 4'd9;   // any units digit
  localparam bcd_t       c_hr_ms_max    = 4'd2;   // tens digit of hour
  localparam bcd_t       c_hr_ls_max_20 = 4'd3;   // units digit when hour is 2x
  localparam logic [7:0] c_hr12_offset  = 8'h12;  // 24 h -> 12 h offset, BCD

  // True when the supplied digits form a valid 24 h time. Seconds digits
  // only matter when the counter actually keeps seconds.
  function automatic logic time_legal(
    input bcd_t hr_ms,
    input bcd_t hr_ls,
    input bcd_t min_ms,
    input bcd_t min_ls,
    input bcd_t sec_ms,
    input bcd_t sec_ls,
    input logic sec_en
  );
    logic ok;
    ok = (hr_ms <= c_hr_ms_max) && (hr_ls <= c_ls_max) &&
         !((hr_ms == c_hr_ms_max) && (hr_ls > c_hr_ls_max_20)) &&
         (min_ms <= c_ms60_max) && (min_ls <= c_ls_max);
    if (sec_en) begin
      ok = ok && (sec_ms <= c_ms60_max) && (sec_ls <= c_ls_max);
    end
    return ok;
  endfunction

endpackage
`default_nettype wire

// File: rtl/aclk_bcd_mod60.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : aclk_bcd_mod60                                             |
// | Description : Two-digit BCD counter 00-59 with load and carry-out.       |
// | Ports       : i_clk     - clock, rising edge                             |
// |               i_reset   - synchronous active-low reset                   |
// |               i_inc     - advance by one                                 |
// |               i_load    - load i_ld_ms/i_ld_ls (wins over i_inc)         |
// |               o_ms/o_ls - current value                                  |
// |               o_carry   - combinational: i_inc while at 59               |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module aclk_bcd_mod60
  import aclk_pkg::*;
#(
  parameter logic [7:0] RST_VAL = 8'h00
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_inc,
  input  logic i_load,
  input  bcd_t i_ld_ms,
  input  bcd_t i_ld_ls,
  output bcd_t o_ms,
  output bcd_t o_ls,
  output logic o_carry
);

  bcd_t r_ms;
  bcd_t r_ls;
  logic w_ls_wrap;
  logic w_at_max;

  assign w_ls_wrap = (r_ls == c_ls_max);
  assign w_at_max  = w_ls_wrap && (r_ms == c_ms60_max);
  // Carry is combinational so the next stage advances on the same edge.
  assign o_carry   = i_inc && w_at_max;

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_ms <= RST_VAL[7:4];
      r_ls <= RST_VAL[3:0];
    end else if (i_load) begin
      r_ms <= i_ld_ms;
      r_ls <= i_ld_ls;
    end else if (i_inc) begin
      if (w_ls_wrap) begin
        r_ls <= '0;
        r_ms <= (r_ms == c_ms60_max) ? '0 : r_ms + 4'd1;
      end else begin
        r_ls <= r_ls + 4'd1;
      end
    end
  end

  assign o_ms = r_ms;
  assign o_ls = r_ls;

endmodule
`default_nettype wire

// File: rtl/aclk_time_counter_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : aclk_time_counter_gen                                      |
// | Description : BCD 24 h time-of-day counter (HH:MM[:SS]) with validated   |
// |               load, count enable, rollover strobes and a registered     |
// |               12 h display view with AM/PM flag.                         |
// | Ports       : i_clk, i_reset (sync, active-low)                          |
// |               i_tick, i_count_en  - count pulse and its enable           |
// |               i_load, i_ld_*      - parallel load request / value        |
// |               i_mode_12h          - display format select                |
// |               o_hr_*/o_min_*/o_sec_* - current time, 24 h BCD            |
// |               o_disp_hr_*, o_pm   - display hour and PM flag             |
// |               o_load_err          - pulse: load rejected                 |
// |               o_min/hr/day_strobe - rollover pulses                      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module aclk_time_counter_gen
  import aclk_pkg::*;
#(
  parameter bit         SEC_EN  = 1'b1,
  parameter logic [7:0] RST_HR  = 8'h00,
  parameter logic [7:0] RST_MIN = 8'h00
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_tick,
  input  logic       i_count_en,
  input  logic       i_load,
  input  logic       i_mode_12h,
  input  logic [3:0] i_ld_hr_ms,
  input  logic [3:0] i_ld_hr_ls,
  input  logic [3:0] i_ld_min_ms,
  input  logic [3:0] i_ld_min_ls,
  input  logic [3:0] i_ld_sec_ms,
  input  logic [3:0] i_ld_sec_ls,
  output logic [3:0] o_hr_ms,
  output logic [3:0] o_hr_ls,
  output logic [3:0] o_min_ms,
  output logic [3:0] o_min_ls,
  output logic [3:0] o_sec_ms,
  output logic [3:0] o_sec_ls,
  output logic [3:0] o_disp_hr_ms,
  output logic [3:0] o_disp_hr_ls,
  output logic       o_pm,
  output logic       o_load_err,
  output logic       o_min_strobe,
  output logic       o_hr_strobe,
  output logic       o_day_strobe
);

  logic w_ld_legal;
  logic w_ld_ok;
  logic w_tick_acc;
  logic w_min_inc;
  logic w_hr_inc;
  logic w_hr_at_max;
  bcd_t w_sec_ms;
  bcd_t w_sec_ls;
  bcd_t w_min_ms;
  bcd_t w_min_ls;

  bcd_t r_hr_ms;
  bcd_t r_hr_ls;
  bcd_t r_disp_ms;
  bcd_t r_disp_ls;
  logic r_pm;
  logic r_load_err;
  logic r_min_strobe;
  logic r_hr_strobe;
  logic r_day_strobe;

  // 24 h -> display hour. 00 shows as 12; 13-23 subtract 12 digit-wise
  // with a borrow from the tens digit when the units digit is too small.
  function automatic logic [7:0] to_disp(
    input bcd_t hr_ms,
    input bcd_t hr_ls,
    input logic mode_12h
  );
    bcd_t ms;
    bcd_t ls;
    ms = hr_ms;
    ls = hr_ls;
    if (mode_12h) begin
      if ({hr_ms, hr_ls} == 8'h00) begin
        ms = c_hr12_offset[7:4];
        ls = c_hr12_offset[3:0];
      end else if ({hr_ms, hr_ls} > c_hr12_offset) begin
        if (hr_ls >= c_hr12_offset[3:0]) begin
          ls = hr_ls - c_hr12_offset[3:0];
          ms = hr_ms - c_hr12_offset[7:4];
        end else begin
          ls = hr_ls + (4'd10 - c_hr12_offset[3:0]);
          ms = hr_ms - c_hr12_offset[7:4] - 4'd1;
        end
      end
    end
    return {ms, ls};
  endfunction

  assign w_ld_legal = time_legal(i_ld_hr_ms, i_ld_hr_ls, i_ld_min_ms,
                                 i_ld_min_ls, i_ld_sec_ms, i_ld_sec_ls, SEC_EN);
  assign w_ld_ok    = i_load && w_ld_legal;
  // Any load request (legal or not) swallows a coincident tick.
  assign w_tick_acc = i_tick && i_count_en && !i_load;

  generate
    if (SEC_EN) begin : g_sec
      aclk_bcd_mod60 #(.RST_VAL(8'h00)) u_sec (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_inc   (w_tick_acc),
        .i_load  (w_ld_ok),
        .i_ld_ms (i_ld_sec_ms),
        .i_ld_ls (i_ld_sec_ls),
        .o_ms    (w_sec_ms),
        .o_ls    (w_sec_ls),
        .o_carry (w_min_inc)
      );
    end else begin : g_nosec
      assign w_sec_ms  = '0;
      assign w_sec_ls  = '0;
      assign w_min_inc = w_tick_acc;
    end
  endgenerate

  aclk_bcd_mod60 #(.RST_VAL(RST_MIN)) u_min (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_inc   (w_min_inc),
    .i_load  (w_ld_ok),
    .i_ld_ms (i_ld_min_ms),
    .i_ld_ls (i_ld_min_ls),
    .o_ms    (w_min_ms),
    .o_ls    (w_min_ls),
    .o_carry (w_hr_inc)
  );

  assign w_hr_at_max = (r_hr_ms == c_hr_ms_max) && (r_hr_ls == c_hr_ls_max_20);

  // Hour digits, rollover strobes and load error.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_hr_ms      <= RST_HR[7:4];
      r_hr_ls      <= RST_HR[3:0];
      r_min_strobe <= 1'b0;
      r_hr_strobe  <= 1'b0;
      r_day_strobe <= 1'b0;
      r_load_err   <= 1'b0;
    end else begin
      r_min_strobe <= w_min_inc;
      r_hr_strobe  <= w_hr_inc;
      r_day_strobe <= w_hr_inc && w_hr_at_max;
      r_load_err   <= i_load && !w_ld_legal;
      if (w_ld_ok) begin
        r_hr_ms <= i_ld_hr_ms;
        r_hr_ls <= i_ld_hr_ls;
      end else if (w_hr_inc) begin
        if (w_hr_at_max) begin
          r_hr_ms <= '0;
          r_hr_ls <= '0;
        end else if (r_hr_ls == c_ls_max) begin
          r_hr_ls <= '0;
          r_hr_ms <= r_hr_ms + 4'd1;
        end else begin
          r_hr_ls <= r_hr_ls + 4'd1;
        end
      end
    end
  end

  // Display view lags the hour registers by one cycle.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      {r_disp_ms, r_disp_ls} <= to_disp(RST_HR[7:4], RST_HR[3:0], i_mode_12h);
      r_pm                   <= 1'b0;
    end else begin
      {r_disp_ms, r_disp_ls} <= to_disp(r_hr_ms, r_hr_ls, i_mode_12h);
      r_pm                   <= ({r_hr_ms, r_hr_ls} >= c_hr12_offset);
    end
  end

  assign o_hr_ms      = r_hr_ms;
  assign o_hr_ls      = r_hr_ls;
  assign o_min_ms     = w_min_ms;
  assign o_min_ls     = w_min_ls;
  assign o_sec_ms     = w_sec_ms;
  assign o_sec_ls     = w_sec_ls;
  assign o_disp_hr_ms = r_disp_ms;
  assign o_disp_hr_ls = r_disp_ls;
  assign o_pm         = r_pm;
  assign o_load_err   = r_load_err;
  assign o_min_strobe = r_min_strobe;
  assign o_hr_strobe  = r_hr_strobe;
  assign o_day_strobe = r_day_strobe;

endmodule
`default_nettype wire

// File: tb/tb_aclk_time_counter_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_aclk_time_counter_gen                                   |
// | Description : Self-checking bench. Two instances (with and without       |
// |               seconds) share one stimulus; a time-in-units model checks |
// |               every cycle, directed literal checks pin the model.        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_aclk_time_counter_gen;
  import aclk_pkg::*;

  typedef struct packed {
    int         t;      // seconds (or minutes) since midnight
    logic       ms;
    logic       hs;
    logic       ds;
    logic       err;
    logic       pm;
    logic [7:0] disp;
  } mstate_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, tick, count_en, load, mode_12h;
  logic [3:0] ld_hr_ms, ld_hr_ls, ld_min_ms, ld_min_ls, ld_sec_ms, ld_sec_ls;

  wire [23:0] a_time, b_time;
  wire [7:0]  a_disp, b_disp;
  wire        a_pm, a_err, a_ms, a_hs, a_ds;
  wire        b_pm, b_err, b_ms, b_hs, b_ds;

  aclk_time_counter_gen #(.SEC_EN(1'b1), .RST_HR(8'h12), .RST_MIN(8'h34)) u_dut_a (
    .i_clk(clk), .i_reset(reset), .i_tick(tick), .i_count_en(count_en),
    .i_load(load), .i_mode_12h(mode_12h),
    .i_ld_hr_ms(ld_hr_ms), .i_ld_hr_ls(ld_hr_ls), .i_ld_min_ms(ld_min_ms),
    .i_ld_min_ls(ld_min_ls), .i_ld_sec_ms(ld_sec_ms), .i_ld_sec_ls(ld_sec_ls),
    .o_hr_ms(a_time[23:20]), .o_hr_ls(a_time[19:16]), .o_min_ms(a_time[15:12]),
    .o_min_ls(a_time[11:8]), .o_sec_ms(a_time[7:4]), .o_sec_ls(a_time[3:0]),
    .o_disp_hr_ms(a_disp[7:4]), .o_disp_hr_ls(a_disp[3:0]), .o_pm(a_pm),
    .o_load_err(a_err), .o_min_strobe(a_ms), .o_hr_strobe(a_hs), .o_day_strobe(a_ds)
  );

  aclk_time_counter_gen #(.SEC_EN(1'b0), .RST_HR(8'h07), .RST_MIN(8'h45)) u_dut_b (
    .i_clk(clk), .i_reset(reset), .i_tick(tick), .i_count_en(count_en),
    .i_load(load), .i_mode_12h(mode_12h),
    .i_ld_hr_ms(ld_hr_ms), .i_ld_hr_ls(ld_hr_ls), .i_ld_min_ms(ld_min_ms),
    .i_ld_min_ls(ld_min_ls), .i_ld_sec_ms(ld_sec_ms), .i_ld_sec_ls(ld_sec_ls),
    .o_hr_ms(b_time[23:20]), .o_hr_ls(b_time[19:16]), .o_min_ms(b_time[15:12]),
    .o_min_ls(b_time[11:8]), .o_sec_ms(b_time[7:4]), .o_sec_ls(b_time[3:0]),
    .o_disp_hr_ms(b_disp[7:4]), .o_disp_hr_ls(b_disp[3:0]), .o_pm(b_pm),
    .o_load_err(b_err), .o_min_strobe(b_ms), .o_hr_strobe(b_hs), .o_day_strobe(b_ds)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [7:0] bcd2(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic int hour_of(input int t, input bit sec_en);
    return sec_en ? t / 3600 : t / 60;
  endfunction

  function automatic logic [23:0] time_bcd(input int t, input bit sec_en);
    if (sec_en) return {bcd2(t / 3600), bcd2((t / 60) % 60), bcd2(t % 60)};
    return {bcd2(t / 60), bcd2(t % 60), 8'h00};
  endfunction

  function automatic logic [7:0] disp_of(input int h, input logic m12);
    int v;
    v = h;
    if (m12) v = (h == 0) ? 12 : (h > 12 ? h - 12 : h);
    return bcd2(v);
  endfunction

  function automatic mstate_t model_step(input mstate_t s, input bit sec_en,
                                         input int rst_t, input int rst_h);
    mstate_t n;
    int units, ld_t;
    units = sec_en ? 86400 : 1440;
    n = s;
    n.ms = 0; n.hs = 0; n.ds = 0; n.err = 0;
    if (!reset) begin
      n.t = rst_t; n.pm = 0; n.disp = disp_of(rst_h, mode_12h);
      return n;
    end
    n.pm   = (hour_of(s.t, sec_en) >= 12);
    n.disp = disp_of(hour_of(s.t, sec_en), mode_12h);
    if (load) begin
      if (time_legal(ld_hr_ms, ld_hr_ls, ld_min_ms, ld_min_ls, ld_sec_ms, ld_sec_ls, sec_en)) begin
        ld_t = (int'(ld_hr_ms) * 10 + int'(ld_hr_ls)) * 60 + int'(ld_min_ms) * 10 + int'(ld_min_ls);
        if (sec_en) ld_t = ld_t * 60 + int'(ld_sec_ms) * 10 + int'(ld_sec_ls);
        n.t = ld_t;
      end else begin
        n.err = 1;
      end
    end else if (tick && count_en) begin
      n.t  = (s.t + 1) % units;
      n.ms = sec_en ? (n.t % 60 == 0) : 1'b1;
      n.hs = sec_en ? (n.t % 3600 == 0) : (n.t % 60 == 0);
      n.ds = (n.t == 0);
    end
    return n;
  endfunction

  mstate_t m_a, m_b;
  logic    m_valid = 1'b0;

  always @(posedge clk) begin
    m_a <= model_step(m_a, 1'b1, 12 * 3600 + 34 * 60, 12);
    m_b <= model_step(m_b, 1'b0, 7 * 60 + 45, 7);
    if (!reset) m_valid <= 1'b1;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("a_time",    {8'h0, a_time}, {8'h0, time_bcd(m_a.t, 1'b1)});
      check("a_disp",    {24'h0, a_disp}, {24'h0, m_a.disp});
      check("a_pm_err",  {30'h0, a_pm, a_err}, {30'h0, m_a.pm, m_a.err});
      check("a_strobes", {29'h0, a_ms, a_hs, a_ds}, {29'h0, m_a.ms, m_a.hs, m_a.ds});
      check("b_time",    {8'h0, b_time}, {8'h0, time_bcd(m_b.t, 1'b0)});
      check("b_disp",    {24'h0, b_disp}, {24'h0, m_b.disp});
      check("b_pm_err",  {30'h0, b_pm, b_err}, {30'h0, m_b.pm, m_b.err});
      check("b_strobes", {29'h0, b_ms, b_hs, b_ds}, {29'h0, m_b.ms, m_b.hs, m_b.ds});
    end
  end

  // ---------------- stimulus ----------------
  task automatic advance();
    @(negedge clk);
    #1;
  endtask

  task automatic set_ld(input logic [23:0] v);
    {ld_hr_ms, ld_hr_ls, ld_min_ms, ld_min_ls, ld_sec_ms, ld_sec_ls} = v;
  endtask

  task automatic do_load(input logic [23:0] v, input bit with_tick);
    set_ld(v);
    load = 1'b1;
    tick = with_tick;
    advance();
    load = 1'b0;
    tick = 1'b0;
  endtask

  task automatic do_tick();
    tick = 1'b1;
    advance();
    tick = 1'b0;
  endtask

  initial begin
    reset = 1'b0; tick = 1'b0; count_en = 1'b1; load = 1'b0; mode_12h = 1'b1;
    set_ld(24'h0);
    repeat (3) advance();
    reset = 1'b1;
    advance();
    // Reset value 12:34:00, PM, shows 12 in 12 h mode
    check("rst_time",   {8'h0, a_time}, 32'h00123400);
    check("rst_disp",   {24'h0, a_disp}, 32'h12);
    check("rst_pm",     {31'h0, a_pm}, 32'h1);
    check("rst_strobe", {29'h0, a_ms, a_hs, a_ds}, 32'h0);
    check("rst_time_b", {8'h0, b_time}, 32'h00074500);

    // Midnight rollover
    do_load(24'h235958, 1'b0);
    do_tick();
    check("t235959", {8'h0, a_time}, 32'h00235959);
    do_tick();
    check("midnight",    {8'h0, a_time}, 32'h00000000);
    check("midnight_st", {29'h0, a_ms, a_hs, a_ds}, 32'h7);
    check("midnight_pm", {31'h0, a_pm}, 32'h1);
    advance();
    check("pm_drop",     {31'h0, a_pm}, 32'h0);
    check("strobe_gone", {29'h0, a_ms, a_hs, a_ds}, 32'h0);

    // Hour tens carry
    do_load(24'h095959, 1'b0);
    do_tick();
    check("t100000", {8'h0, a_time}, 32'h00100000);
    check("t10_hs",  {31'h0, a_hs}, 32'h1);
    do_load(24'h195959, 1'b0);
    do_tick();
    check("t200000", {8'h0, a_time}, 32'h00200000);
    advance();
    check("disp_08", {24'h0, a_disp}, 32'h08);
    check("pm_20",   {31'h0, a_pm}, 32'h1);

    // Illegal loads leave time alone
    do_load(24'h240000, 1'b0);
    check("err_24", {31'h0, a_err}, 32'h1);
    check("keep_24", {8'h0, a_time}, 32'h00200000);
    do_load(24'h126000, 1'b0);
    check("err_60", {31'h0, a_err}, 32'h1);
    do_load(24'h07155A, 1'b0);
    check("err_5A", {31'h0, a_err}, 32'h1);
    check("b_ok_5A", {8'h0, b_time}, 32'h00071500);
    advance();
    check("err_pulse", {31'h0, a_err}, 32'h0);
    do_load(24'h102030, 1'b1);
    check("ld_tick", {8'h0, a_time}, 32'h00102030);

    // Frozen count
    count_en = 1'b0;
    repeat (5) do_tick();
    check("frozen", {8'h0, a_time}, 32'h00102030);
    count_en = 1'b1;

    // Minute-only instance hour carry
    do_load(24'h005900, 1'b0);
    do_tick();
    check("b_0100",  {8'h0, b_time}, 32'h00010000);
    check("b_0100_hs", {31'h0, b_hs}, 32'h1);

    // Reset beats a coincident tick
    do_load(24'h235959, 1'b0);
    reset = 1'b0;
    tick  = 1'b1;
    advance();
    reset = 1'b1;
    tick  = 1'b0;
    check("rst_tick", {8'h0, a_time}, 32'h00123400);
    check("rst_tick_st", {29'h0, a_ms, a_hs, a_ds}, 32'h0);

    // Random phase
    for (int i = 0; i < 3000; i++) begin
      reset    = ($urandom_range(0, 199) != 0);
      count_en = ($urandom_range(0, 9) != 0);
      tick     = ($urandom_range(0, 3) != 0);
      load     = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 9) == 0) mode_12h = ~mode_12h;
      if ($urandom_range(0, 1) == 0) begin
        set_ld(24'($urandom));
      end else begin
        ld_hr_ms  = 4'($urandom_range(0, 2));
        ld_hr_ls  = (ld_hr_ms == 4'd2) ? 4'($urandom_range(0, 3)) : 4'd9;
        ld_min_ms = 4'd5;
        ld_min_ls = 4'($urandom_range(8, 9));
        ld_sec_ms = 4'd5;
        ld_sec_ls = 4'($urandom_range(0, 9));
      end
      advance();
    end
    reset = 1'b1; tick = 1'b0; load = 1'b0;
    advance();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
